m_serial_adder: RTL
===================

// Module: m_serial_adder
// PURPOSE
//  Multi-cycle digit-serial adder/subtractor, successor to the 1-bit full adder.
//  Adds (or subtracts) two WIDTH-bit operands DIGIT bits per clock.
//  - Datapath: a DIGIT-wide ripple of full adders plus one carry register.
//  - Control: start/ready handshake on input, one-cycle valid pulse on output.
//  - Used where area matters more than latency, e.g. the processor's slow ALU path.
// PARAMETERS
//  WIDTH  32  operand/result width in bits; must be a multiple of DIGIT
//  DIGIT   4  bits processed per cycle (1 = pure bit-serial); 1 <= DIGIT <= WIDTH
// PORTS
//  w_clk    in   1      clock, rising edge
//  w_rst    in   1      reset, asynchronous, active-high
//  w_start  in   1      request; accepted on a rising edge where w_ready=1
//  w_ready  out  1      1 in IDLE and DONE; 0 in RUN
//  w_a      in   WIDTH  operand A, sampled on accept
//  w_b      in   WIDTH  operand B, sampled on accept
//  w_cin    in   1      carry-in (add) or borrow-in (sub), sampled on accept
//  w_sub    in   1      0: A+B+cin; 1: A-B-cin; sampled on accept
//  w_s      out  WIDTH  result, held stable from w_valid until the next accept
//  w_cout   out  1      add: carry-out; sub: 1 = no borrow (A >= B+cin, unsigned)
//  w_valid  out  1      one-cycle pulse, result ready
// BEHAVIOUR
//  Derived constant: N = WIDTH/DIGIT digits.
//  Reset (async, any state, including mid-operation):
//   - State -> IDLE; w_s=0, w_cout=0, w_valid=0, w_ready=1, counter=0.
//   - Any in-flight operation is discarded; no valid pulse is produced.
//  State machine (IDLE, RUN, DONE):
//   - IDLE: start -> RUN. Latch A; latch B, or ~B if sub.
//     Carry register <= cin (add) or ~cin (sub). Counter <= 0.
//   - RUN: each cycle, add digit[counter] of A, B and the carry register
//     through the DIGIT-bit ripple.
//     Write the sum digit into w_s[counter*DIGIT +: DIGIT]; carry register <= ripple carry.
//     Counter increments; after the digit N-1 cycle -> DONE.
//     w_start is ignored in RUN.
//   - DONE: w_valid=1 for exactly this cycle; w_cout = final carry.
//     Start -> RUN (back-to-back, no idle gap); no start -> IDLE.
//  Latency: accept at edge k; w_valid high in the cycle after edge k+N;
//   throughput 1 op per N+1 cycles.
//  w_s is undefined-but-stable during RUN; the bench checks it only at w_valid.
//  Arithmetic: modulo 2^WIDTH; the counter is wide enough for N-1 and never wraps.
//  N=1 (DIGIT=WIDTH): RUN lasts one cycle; behaves as a registered adder.
//  Inputs change while not accepting: no effect on an in-flight result.
// CONFIGURATION
//  Macro SERIAL_ADDER_OVF_EN.
//  Defined:
//   - Extra output w_ovf (1 bit): two's-complement signed overflow of the op.
//   - w_ovf = carry into MSB XOR carry out of MSB.
//   - Valid with w_valid, held with w_s; reset 0.
//  Undefined: port w_ovf and its logic absent; all other behaviour identical.
// TESTING (WIDTH=8, DIGIT=2 unless stated)
//  1. Reset: assert w_rst mid-RUN -> next cycle w_ready=1, w_valid=0, w_s=0;
//     no pulse follows.
//  2. Add: A=8'h5A, B=8'h3C, cin=0, sub=0 -> w_valid 4 cycles after accept+1;
//     w_s=8'h96, w_cout=0, w_ovf=1.
//  3. Add carry: A=8'hFF, B=8'h00, cin=1 -> w_s=8'h00, w_cout=1, w_ovf=0.
//  4. Sub: A=8'h10, B=8'h20, cin=0, sub=1 -> w_s=8'hF0, w_cout=0 (borrow).
//     A=8'h20, B=8'h10 -> w_s=8'h10, w_cout=1.
//  5. Back-to-back: start held high -> consecutive w_valid pulses exactly
//     5 cycles apart; start during RUN ignored.
//  6. Sweep: DIGIT=1 and DIGIT=8, all 2^17 (A,B,cin) with sub=0/1 random sample
//     -> matches {cout,s} reference model.

Source files
------------

// File: rtl/m_serial_adder.sv
// Digit-serial adder/subtractor: DIGIT bits of A+/-B per clock, one carry register between digits.
// Latency: accept at edge k, w_valid pulses in the cycle after edge k+N (N=WIDTH/DIGIT); one op per N+1 cycles.
// Backpressure: w_ready is low during RUN and w_start is ignored there. Optional w_ovf output via `SERIAL_ADDER_OVF_EN.
module m_serial_adder #(
    parameter int WIDTH = 32,
    parameter int DIGIT = 4
) (
    input  logic             w_clk,
    input  logic             w_rst,
    input  logic             w_start,
    output logic             w_ready,
    input  logic [WIDTH-1:0] w_a,
    input  logic [WIDTH-1:0] w_b,
    input  logic             w_cin,
    input  logic             w_sub,
    output logic [WIDTH-1:0] w_s,
    output logic             w_cout,
`ifdef SERIAL_ADDER_OVF_EN
    output logic             w_ovf,
`endif
    output logic             w_valid
);

    localparam int N  = WIDTH / DIGIT;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [WIDTH-1:0]  a_q, b_q, s_q;
    logic              carry_q, cout_q;
    logic [CW-1:0]     cnt_q;
    logic [31:0]       base;
    logic [DIGIT-1:0]  a_dig, b_dig, sum_d;
    logic              c_out;
    logic              accept, last;
`ifdef SERIAL_ADDER_OVF_EN
    logic              c_msb;
    logic              ovf_q;
`endif

    assign w_ready = (state_q != RUN);
    assign w_valid = (state_q == DONE);
    assign accept  = w_ready && w_start;
    assign last    = (cnt_q == CW'(N - 1));
    assign base    = 32'(cnt_q) * 32'(DIGIT);
    assign a_dig   = a_q[base +: DIGIT];
    assign b_dig   = b_q[base +: DIGIT];
    assign w_s     = s_q;
    assign w_cout  = cout_q;
`ifdef SERIAL_ADDER_OVF_EN
    assign w_ovf   = ovf_q;
`endif

    // DIGIT-wide ripple; the carry into the top bit is kept for the signed overflow flag
    always_comb begin
        logic c;
        c     = carry_q;
        sum_d = '0;
`ifdef SERIAL_ADDER_OVF_EN
        c_msb = 1'b0;
`endif
        for (int i = 0; i < DIGIT; i++) begin
`ifdef SERIAL_ADDER_OVF_EN
            c_msb = c;
`endif
            sum_d[i] = a_dig[i] ^ b_dig[i] ^ c;
            c        = (a_dig[i] & b_dig[i]) | (c & (a_dig[i] ^ b_dig[i]));
        end
        c_out = c;
    end

    always_ff @(posedge w_clk or posedge w_rst) begin
        if (w_rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (w_start) state_d = RUN;
            RUN:     if (last) state_d = DONE;
            DONE:    state_d = w_start ? RUN : IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Subtraction is A + ~B + ~borrow, so the final carry reads as "no borrow"
    always_ff @(posedge w_clk or posedge w_rst) begin
        if (w_rst) begin
            a_q     <= '0;
            b_q     <= '0;
            s_q     <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            cnt_q   <= '0;
`ifdef SERIAL_ADDER_OVF_EN
            ovf_q   <= 1'b0;
`endif
        end else if (accept) begin
            a_q     <= w_a;
            b_q     <= w_sub ? ~w_b : w_b;
            carry_q <= w_cin ^ w_sub;
            cnt_q   <= '0;
        end else if (state_q == RUN) begin
            s_q[base +: DIGIT] <= sum_d;
            carry_q            <= c_out;
            if (last) begin
                cnt_q  <= '0;
                cout_q <= c_out;
`ifdef SERIAL_ADDER_OVF_EN
                ovf_q  <= c_out ^ c_msb;
`endif
            end else begin
                cnt_q <= cnt_q + CW'(1);
            end
        end
    end

endmodule
